bus_copy_master: RTL

BUS_COPY_MASTER -- requirements
Module: bus_copy_master

---
 rtl/bus_pkg.sv | 17 +
 rtl/bus_copy_master.sv | 128 ++++++++++++
 2 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions: default widths and the copy-master state encoding,
// used by the RTL and by bus-side testbenches.
package bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 64;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RD   = 3'd2,
    S_RDW  = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_e;

endpackage

// File: rtl/bus_copy_master.sv
// Bus master that copies len words from src_addr to dst_addr, one read and one
// write per word, through a single-word buffer. All outputs are flops.
module bus_copy_master #(
  parameter int ADDR_W   = bus_pkg::ADDR_W,
  parameter int DATA_W   = bus_pkg::DATA_W,
  parameter int ADDR_INC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [7:0]        len,
  output logic              busy,
  output logic              done,
  output logic              m_req,
  input  logic              m_grant,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_dout,
  input  logic [DATA_W-1:0] m_din
);
  import bus_pkg::*;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_INC);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d;
  logic [7:0]          rem_q, rem_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                m_req_q, m_req_d, m_wr_q, m_wr_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_dout_q, m_dout_d;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    rem_d    = rem_q;
    buf_d    = buf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != 8'd0) begin
            src_d   = src_addr;
            dst_d   = dst_addr;
            rem_d   = len;
            state_d = S_REQ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_REQ:  if (m_grant) state_d = S_RD;
      S_RD:   if (m_grant) state_d = S_RDW;
      S_RDW: begin
        buf_d   = m_din;
        state_d = S_WR;
      end
      S_WR: begin
        if (m_grant) begin
          src_d   = src_q + STEP;
          dst_d   = dst_q + STEP;
          rem_d   = rem_q - 8'd1;
          state_d = (rem_q == 8'd1) ? S_DONE : S_RD;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over any other transition, including the final write.
    if (abort && state_q != S_IDLE) state_d = S_IDLE;

    // Outputs are registered copies of the decode of the next state.
    busy_d   = state_d inside {S_REQ, S_RD, S_RDW, S_WR};
    m_req_d  = busy_d;
    done_d   = (state_d == S_DONE);
    m_wr_d   = (state_d == S_WR);
    m_addr_d = m_addr_q;
    m_dout_d = m_dout_q;
    if (state_d == S_RD) m_addr_d = src_d;
    if (state_d == S_WR) begin
      m_addr_d = dst_d;
      m_dout_d = buf_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      rem_q    <= '0;
      buf_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      m_req_q  <= 1'b0;
      m_wr_q   <= 1'b0;
      m_addr_q <= '0;
      m_dout_q <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      rem_q    <= rem_d;
      buf_q    <= buf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      m_req_q  <= m_req_d;
      m_wr_q   <= m_wr_d;
      m_addr_q <= m_addr_d;
      m_dout_q <= m_dout_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign m_req  = m_req_q;
  assign m_wr   = m_wr_q;
  assign m_addr = m_addr_q;
  assign m_dout = m_dout_q;

endmodule
